// File: rtl/if_id_decode.sv
// IF/ID pipeline register with decode stage: field extraction, 32x64 register
// file with write-first bypass, and RV64 immediate generation.
module if_id_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC_F,
  input  logic [31:0] Instr_F,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        RegWrite_W,
  input  logic [4:0]  Rd_W,
  input  logic [63:0] Result_W,
  output logic [63:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D,
  output logic [4:0]  Rs1_D,
  output logic [4:0]  Rs2_D,
  output logic [4:0]  Rd_D,
  output logic [63:0] RD1_D,
  output logic [63:0] RD2_D,
  output logic [63:0] ImmExt_D
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Valid_D qualifies Instr_D: 1 = fetched instruction, 0 = bubble (NOP).
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (FlushD) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      pc_d    = PC_F;
      instr_d = Instr_F;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign PC_D    = pc_q;
  assign Instr_D = instr_q;
  assign Valid_D = valid_q;

  assign Rs1_D = instr_q[19:15];
  assign Rs2_D = instr_q[24:20];
  assign Rd_D  = instr_q[11:7];

  // Register file writes are independent of stall/flush; only reset blocks them.
  logic [63:0] regs_q [32];
  logic        wr_en;

  assign wr_en = RegWrite_W && (Rd_W != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[Rd_W] <= Result_W;
    end
  end

  always_comb begin
    RD1_D = '0;
    RD2_D = '0;
    if (Rs1_D != 5'd0) RD1_D = (wr_en && Rd_W == Rs1_D) ? Result_W : regs_q[Rs1_D];
    if (Rs2_D != 5'd0) RD2_D = (wr_en && Rd_W == Rs2_D) ? Result_W : regs_q[Rs2_D];
  end

  // Shift-immediates pass through as plain I-type; shamt is picked out downstream.
  always_comb begin
    ImmExt_D = '0;
    unique case (instr_q[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        ImmExt_D = {{52{instr_q[31]}}, instr_q[31:20]};
      OP_STORE:
        ImmExt_D = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        ImmExt_D = {{52{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        ImmExt_D = {{32{instr_q[31]}}, instr_q[31:12], 12'b0};
      OP_JAL:
        ImmExt_D = {{44{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      default:
        ImmExt_D = '0;
    endcase
  end

endmodule

// File: tb/tb_if_id_decode.sv
// Bench for if_id_decode: table of fetch vectors checked through an expected
// queue, plus hand sequences for register file, stall, flush and reset.
module tb_if_id_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] PC_F;
  logic [31:0] Instr_F;
  logic        StallD, FlushD, RegWrite_W;
  logic [4:0]  Rd_W;
  logic [63:0] Result_W;
  logic [63:0] PC_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic [63:0] RD1_D, RD2_D, ImmExt_D;

  if_id_decode dut (
    .clk(clk), .rst(rst), .PC_F(PC_F), .Instr_F(Instr_F),
    .StallD(StallD), .FlushD(FlushD), .RegWrite_W(RegWrite_W),
    .Rd_W(Rd_W), .Result_W(Result_W),
    .PC_D(PC_D), .Instr_D(Instr_D), .Valid_D(Valid_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D)
  );

  // Clock / counters
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
  } vec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    RegWrite_W = 1'b0; Rd_W = '0; Result_W = '0;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [63:0] val);
    RegWrite_W = 1'b1; Rd_W = rd; Result_W = val;
    tick();
    RegWrite_W = 1'b0; Rd_W = '0; Result_W = '0;
  endtask

  task automatic load(input logic [63:0] pc, input logic [31:0] instr);
    PC_F = pc; Instr_F = instr;
    tick();
  endtask

  initial begin
    exp_t e;
    int n;

    vecs[0]  = '{64'h8,    32'h00500093, 64'h5};
    vecs[1]  = '{64'h10,   32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{64'h14,   32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[3]  = '{64'h18,   32'h800000B7, 64'hFFFF_FFFF_8000_0000};
    vecs[4]  = '{64'h1C,   32'h0000006F, 64'h0};
    vecs[5]  = '{64'h20,   32'hFE20BC23, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[6]  = '{64'h24,   32'h12345097, 64'h0000_0000_1234_5000};
    vecs[7]  = '{64'h28,   32'h002081B3, 64'h0};
    vecs[8]  = '{64'h2C,   32'h008000EF, 64'h8};
    vecs[9]  = '{64'h30,   32'hFF013283, 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[10] = '{64'h34,   32'h03F09093, 64'h3F};
    vecs[11] = '{64'h38,   32'h4030D093, 64'h403};
    vecs[12] = '{64'h3C,   32'hFFC08067, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[13] = '{64'h40,   32'h0010809B, 64'h1};
    vecs[14] = '{64'hFFFF_FFFF_FFFF_FFF0, 32'h2080003B, 64'h0};

    // Reset
    idle_inputs();
    PC_F = 64'hDEAD; Instr_F = 32'h00500093;
    rst = 1'b1;
    tick();
    check("reset_pc", PC_D, 64'h0);
    check("reset_instr", {32'h0, Instr_D}, 64'h13);
    check("reset_valid", {63'h0, Valid_D}, 64'h0);
    check("reset_imm", ImmExt_D, 64'h0);
    rst = 1'b0;

    // Table-driven fetch vectors through the expected queue
    for (int i = 0; i < 15; i++) begin
      PC_F = vecs[i].pc; Instr_F = vecs[i].instr;
      exp_q.push_back('{pc: vecs[i].pc, instr: vecs[i].instr, imm: vecs[i].imm});
      tick();
      if (exp_q.size() == 0) begin
        check("queue_empty", 64'h1, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_pc", i), PC_D, e.pc);
        check($sformatf("v%0d_instr", i), {32'h0, Instr_D}, {32'h0, e.instr});
        check($sformatf("v%0d_valid", i), {63'h0, Valid_D}, 64'h1);
        check($sformatf("v%0d_imm", i), ImmExt_D, e.imm);
        check($sformatf("v%0d_rd", i), {59'h0, Rd_D}, {59'h0, e.instr[11:7]});
        check($sformatf("v%0d_rs1", i), {59'h0, Rs1_D}, {59'h0, e.instr[19:15]});
        check($sformatf("v%0d_rs2", i), {59'h0, Rs2_D}, {59'h0, e.instr[24:20]});
        check($sformatf("v%0d_rd1_zero", i), RD1_D, 64'h0);
        check($sformatf("v%0d_rd2_zero", i), RD2_D, 64'h0);
      end
    end

    // Register write then read, plus same-cycle write-first bypass
    write_reg(5'd5, 64'h1234);
    load(64'h44, 32'h00028313);
    check("rf_read_x5", RD1_D, 64'h1234);
    RegWrite_W = 1'b1; Rd_W = 5'd5; Result_W = 64'hABCD;
    #1;
    check("rf_bypass_x5", RD1_D, 64'hABCD);
    tick();
    RegWrite_W = 1'b0; Rd_W = '0; Result_W = '0;
    #1;
    check("rf_after_bypass_x5", RD1_D, 64'hABCD);

    // RD2 path and bypass on rs2 only
    write_reg(5'd1, 64'h1111_0000_0000_0001);
    write_reg(5'd2, 64'h2222);
    load(64'h48, 32'h002081B3);
    check("rf_rd1_x1", RD1_D, 64'h1111_0000_0000_0001);
    check("rf_rd2_x2", RD2_D, 64'h2222);
    RegWrite_W = 1'b1; Rd_W = 5'd2; Result_W = 64'h5A5A;
    #1;
    check("rf_bypass_rs2", RD2_D, 64'h5A5A);
    check("rf_no_bypass_rs1", RD1_D, 64'h1111_0000_0000_0001);
    RegWrite_W = 1'b0; Rd_W = '0; Result_W = '0;

    // Writes to x0 are discarded, including the bypass path
    write_reg(5'd0, 64'hFFFF);
    load(64'h4C, 32'h00000313);
    check("x0_after_write", RD1_D, 64'h0);
    RegWrite_W = 1'b1; Rd_W = 5'd0; Result_W = 64'hFFFF;
    #1;
    check("x0_no_bypass", RD1_D, 64'h0);
    RegWrite_W = 1'b0; Rd_W = '0; Result_W = '0;

    // Stall holds for two edges while fetch changes; register writes continue
    load(64'h100, 32'h00500093);
    StallD = 1'b1;
    n = 0;
    repeat (2) begin
      PC_F = 64'h200 + 64'(n * 4);
      Instr_F = 32'h00100113 + 32'(n << 20);
      tick();
      n++;
    end
    check("stall_instr", {32'h0, Instr_D}, 64'h00500093);
    check("stall_pc", PC_D, 64'h100);
    check("stall_valid", {63'h0, Valid_D}, 64'h1);
    write_reg(5'd7, 64'h77);

    // Flush wins over simultaneous stall
    FlushD = 1'b1;
    tick();
    check("flush_instr", {32'h0, Instr_D}, 64'h13);
    check("flush_valid", {63'h0, Valid_D}, 64'h0);
    check("flush_pc", PC_D, 64'h0);
    FlushD = 1'b0; StallD = 1'b0;
    load(64'h104, 32'h00038093);
    check("write_during_stall", RD1_D, 64'h77);
    check("load_after_flush_valid", {63'h0, Valid_D}, 64'h1);

    // Reset mid-stall discards the held instruction and clears the register file
    load(64'h300, 32'h00018093);
    write_reg(5'd3, 64'h7);
    check("x3_written", RD1_D, 64'h7);
    StallD = 1'b1;
    tick();
    rst = 1'b1; RegWrite_W = 1'b1; Rd_W = 5'd4; Result_W = 64'h99;
    tick();
    check("rst_stall_valid", {63'h0, Valid_D}, 64'h0);
    check("rst_stall_instr", {32'h0, Instr_D}, 64'h13);
    check("rst_stall_pc", PC_D, 64'h0);
    idle_inputs();
    load(64'h304, 32'h00018093);
    check("post_rst_load_pc", PC_D, 64'h304);
    check("post_rst_x3", RD1_D, 64'h0);
    load(64'h308, 32'h00020093);
    check("rst_blocks_write_x4", RD1_D, 64'h0);

    // Summary
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
